// File: rtl/bitwise_logic_array_pipe_if.sv
// Handshake and operand/result bundle for the bitwise logic array stage.
// master drives operands and downstream ready; slave is the array stage itself.
interface bitwise_logic_array_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned PW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             out_zero;
  logic             out_ones;
  logic [PW-1:0]    out_popcnt;

  modport master (
    output in_valid, a, b, op, acc, acc_clr, out_ready,
    input  in_ready, out_valid, out, out_zero, out_ones, out_popcnt
  );

  modport slave (
    input  in_valid, a, b, op, acc, acc_clr, out_ready,
    output in_ready, out_valid, out, out_zero, out_ones, out_popcnt
  );
endinterface

// File: rtl/bitwise_logic_array_pipe.sv
// Single-stage registered bitwise logic array with eight selectable ops,
// optional accumulator feedback on operand B, and zero/ones/popcount flags.
module bitwise_logic_array_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter bit          ACC_EN = 1'b1
) (
  input logic                     clk,
  input logic                     rst_n,
  bitwise_logic_array_pipe_if.slave bus
);
  localparam int unsigned PW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    OP_OR   = 3'b000,
    OP_AND  = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_XNOR = 3'b101,
    OP_PASS = 3'b110,
    OP_NOTA = 3'b111
  } op_e;

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [PW-1:0]    pc;
  logic             accept;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // A clear in the same cycle as an accumulate is seen as a zero operand.
  always_comb begin
    opb = bus.b;
    if (ACC_EN && bus.acc) opb = bus.acc_clr ? '0 : acc_q;
  end

  always_comb begin
    res = '0;
    case (op_e'(bus.op))
      OP_OR:   res = bus.a | opb;
      OP_AND:  res = bus.a & opb;
      OP_XOR:  res = bus.a ^ opb;
      OP_NOR:  res = ~(bus.a | opb);
      OP_NAND: res = ~(bus.a & opb);
      OP_XNOR: res = ~(bus.a ^ opb);
      OP_PASS: res = bus.a;
      OP_NOTA: res = ~bus.a;
      default: res = '0;
    endcase
  end

  always_comb begin
    pc = '0;
    for (int unsigned i = 0; i < WIDTH; i++) pc = pc + PW'(res[i]);
  end

  generate
    if (ACC_EN) begin : g_acc
      always_ff @(posedge clk) begin
        if (!rst_n)                acc_q <= '0;
        else if (accept && bus.acc) acc_q <= res;
        else if (bus.acc_clr)       acc_q <= '0;
      end
    end else begin : g_noacc
      assign acc_q = '0;
    end
  endgenerate

  // Flags are registered alongside out so they always describe the held result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out        <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_zero   <= 1'b1;
      bus.out_ones   <= 1'b0;
      bus.out_popcnt <= '0;
    end else if (accept) begin
      bus.out        <= res;
      bus.out_valid  <= 1'b1;
      bus.out_zero   <= (res == '0);
      bus.out_ones   <= (res == '1);
      bus.out_popcnt <= pc;
    end else if (bus.out_ready) begin
      bus.out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bitwise_logic_array_pipe.sv
// Bench for bitwise_logic_array_pipe: truth-table reference model compared every
// cycle on a 16-bit instance, directed literal checks, and a WIDTH=1 instance.
module tb_bitwise_logic_array_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  bit   en_cmp = 1'b0;

  always #5 clk = ~clk;

  bitwise_logic_array_pipe_if #(.WIDTH(16)) i16 ();
  bitwise_logic_array_pipe_if #(.WIDTH(1))  i1 ();

  bitwise_logic_array_pipe #(.WIDTH(16), .ACC_EN(1'b1)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(i16.slave));
  bitwise_logic_array_pipe #(.WIDTH(1), .ACC_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(i1.slave));

  // Truth table per op, indexed by {a_bit, b_bit}.
  logic [3:0] tt [8];
  initial begin
    tt[0] = 4'b1110; tt[1] = 4'b1000; tt[2] = 4'b0110; tt[3] = 4'b0001;
    tt[4] = 4'b0111; tt[5] = 4'b1001; tt[6] = 4'b1100; tt[7] = 4'b0011;
  end

  function automatic logic [15:0] model_op(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    logic [15:0] r;
    logic [3:0]  t;
    t = tt[op];
    for (int i = 0; i < 16; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state for the 16-bit instance.
  logic [15:0] m_out = '0;
  logic [15:0] m_acc = '0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    logic [15:0] bb, r;
    logic        rdy;
    if (!rst_n) begin
      m_out = '0; m_valid = 1'b0; m_acc = '0;
    end else begin
      rdy = !m_valid || i16.out_ready;
      bb  = i16.acc ? (i16.acc_clr ? 16'h0000 : m_acc) : i16.b;
      r   = model_op(i16.op, i16.a, bb);
      if (i16.acc_clr) m_acc = '0;
      if (i16.in_valid && rdy) begin
        m_out = r; m_valid = 1'b1;
        if (i16.acc) m_acc = r;
      end else if (i16.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (en_cmp) begin
      check("cmp_valid",  32'(i16.out_valid), 32'(m_valid));
      check("cmp_ready",  32'(i16.in_ready),  32'(!m_valid || i16.out_ready));
      check("cmp_out",    32'(i16.out),       32'(m_out));
      check("cmp_zero",   32'(i16.out_zero),  32'(m_out == 16'h0000));
      check("cmp_ones",   32'(i16.out_ones),  32'(m_out == 16'hFFFF));
      check("cmp_popcnt", 32'(i16.out_popcnt), 32'($countones(m_out)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_ops [8];

  initial begin
    exp_ops[0] = 16'hAFF5; exp_ops[1] = 16'h05A0; exp_ops[2] = 16'hAA55; exp_ops[3] = 16'h500A;
    exp_ops[4] = 16'hFA5F; exp_ops[5] = 16'h55AA; exp_ops[6] = 16'hA5A5; exp_ops[7] = 16'h5A5A;

    i16.in_valid = 0; i16.a = '0; i16.b = '0; i16.op = '0; i16.acc = 0; i16.acc_clr = 0;
    i16.out_ready = 1;
    i1.in_valid = 0; i1.a = '0; i1.b = '0; i1.op = '0; i1.acc = 0; i1.acc_clr = 0;
    i1.out_ready = 1;
    rst_n = 0;
    cyc(); cyc();
    check("rst_out",    32'(i16.out), 32'h0);
    check("rst_valid",  32'(i16.out_valid), 32'h0);
    check("rst_zero",   32'(i16.out_zero), 32'h1);
    check("rst_ones",   32'(i16.out_ones), 32'h0);
    check("rst_popcnt", 32'(i16.out_popcnt), 32'h0);
    check("rst_w1_out", 32'(i1.out), 32'h0);
    rst_n = 1;
    en_cmp = 1;

    // WIDTH=1 corner cases
    i1.in_valid = 1; i1.a = 1'b1; i1.b = 1'b0; i1.op = 3'b000;
    cyc();
    check("w1_or_out",    32'(i1.out), 32'h1);
    check("w1_or_ones",   32'(i1.out_ones), 32'h1);
    check("w1_or_popcnt", 32'(i1.out_popcnt), 32'h1);
    check("w1_or_valid",  32'(i1.out_valid), 32'h1);
    i1.op = 3'b001;
    cyc();
    check("w1_and_out",  32'(i1.out), 32'h0);
    check("w1_and_zero", 32'(i1.out_zero), 32'h1);
    i1.a = 1'b0; i1.op = 3'b011;
    cyc();
    check("w1_nor_out", 32'(i1.out), 32'h1);
    i1.in_valid = 0;

    // Basic OR
    i16.a = 16'h00F0; i16.b = 16'h0F0F; i16.op = 3'b000; i16.in_valid = 1;
    cyc();
    check("or_out",    32'(i16.out), 32'h0FFF);
    check("or_valid",  32'(i16.out_valid), 32'h1);
    check("or_popcnt", 32'(i16.out_popcnt), 32'd12);
    check("or_zero",   32'(i16.out_zero), 32'h0);

    // All ops back-to-back
    i16.a = 16'hA5A5; i16.b = 16'h0FF0;
    for (int k = 0; k < 8; k++) begin
      i16.op = 3'(k);
      cyc();
      check("ops_out", 32'(i16.out), 32'(exp_ops[k]));
      check("ops_valid", 32'(i16.out_valid), 32'h1);
    end

    // Backpressure
    i16.a = 16'h1111; i16.b = 16'h0000; i16.op = 3'b000;
    cyc();
    check("bp_first", 32'(i16.out), 32'h1111);
    i16.out_ready = 0; i16.a = 16'h2222;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("bp_hold_out", 32'(i16.out), 32'h1111);
      check("bp_hold_rdy", 32'(i16.in_ready), 32'h0);
    end
    i16.out_ready = 1;
    cyc();
    check("bp_next", 32'(i16.out), 32'h2222);
    i16.in_valid = 0;
    cyc();
    check("drain_valid", 32'(i16.out_valid), 32'h0);
    check("drain_out",   32'(i16.out), 32'h2222);

    // Accumulate
    i16.acc_clr = 1;
    cyc();
    i16.acc_clr = 0; i16.acc = 1; i16.op = 3'b000; i16.in_valid = 1; i16.b = 16'hFFFF;
    i16.a = 16'h0001; cyc(); check("acc_1", 32'(i16.out), 32'h0001);
    i16.a = 16'h0010; cyc(); check("acc_2", 32'(i16.out), 32'h0011);
    i16.a = 16'h0100; cyc(); check("acc_3", 32'(i16.out), 32'h0111);
    i16.op = 3'b010; i16.a = 16'h0111;
    cyc();
    check("acc_xor",  32'(i16.out), 32'h0000);
    check("acc_zero", 32'(i16.out_zero), 32'h1);

    // Clear / accumulate collision
    i16.op = 3'b110; i16.a = 16'h00FF;
    cyc(); check("coll_seed", 32'(i16.out), 32'h00FF);
    i16.acc_clr = 1; i16.op = 3'b000; i16.a = 16'h1200;
    cyc(); check("coll_out", 32'(i16.out), 32'h1200);
    i16.acc_clr = 0; i16.a = 16'h0000;
    cyc(); check("coll_acc", 32'(i16.out), 32'h1200);

    // Mid-operation reset
    i16.acc = 0; i16.op = 3'b110; i16.a = 16'hABCD;
    cyc();
    i16.out_ready = 0; i16.in_valid = 0; rst_n = 0;
    cyc();
    rst_n = 1;
    check("mrst_valid", 32'(i16.out_valid), 32'h0);
    check("mrst_out",   32'(i16.out), 32'h0);
    check("mrst_rdy",   32'(i16.in_ready), 32'h1);
    i16.out_ready = 1; i16.in_valid = 1; i16.acc = 1; i16.op = 3'b000; i16.a = 16'h0000;
    cyc();
    check("mrst_acc", 32'(i16.out), 32'h0);

    // Randomized traffic checked by the model
    for (int k = 0; k < 400; k++) begin
      i16.in_valid  = ($urandom_range(0, 3) != 0);
      i16.out_ready = ($urandom_range(0, 3) != 0);
      i16.a         = 16'($urandom);
      i16.b         = 16'($urandom);
      i16.op        = 3'($urandom_range(0, 7));
      i16.acc       = ($urandom_range(0, 2) == 0);
      i16.acc_clr   = ($urandom_range(0, 7) == 0);
      rst_n         = ($urandom_range(0, 49) != 0);
      cyc();
    end
    rst_n = 1;
    i16.in_valid = 0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bitwise_logic_array_pipe.md
Name: bitwise_logic_array_pipe

Overview:
- Parametrised successor of the fixed 16-bit OR array.
- Computes one of eight selectable bitwise operations across two WIDTH-bit operands.
- Result is registered behind a valid/ready handshake, with an optional accumulate mode that folds successive inputs into an internal register.
- Used as the generic logic-array stage between datapath registers. Also provides zero, all-ones and popcount status on the registered result.

Parameters:
- WIDTH, 16, operand/result width in bits (>=1).
- ACC_EN, 1, 1 = accumulate mode available; 0 = acc/acc_clr ignored, accumulator removed.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands/op present
- in_ready  output  1  block can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (replaced by accumulator when acc=1)
- op  input  3  operation select
- acc  input  1  accumulate-mode transaction
- acc_clr  input  1  clear accumulator
- out_valid  output  1  result register holds valid data
- out_ready  input  1  downstream accepts result
- out  output  WIDTH  registered result
- out_zero  output  1  out == 0
- out_ones  output  1  out == all ones
- out_popcnt  output  $clog2(WIDTH+1)  number of set bits in out

Behaviour:
- Reset: one clock with rst_n=0 at a rising edge sets out=0, out_valid=0, accumulator=0, out_zero=1, out_ones=0, out_popcnt=0. Reset overrides every other input, including mid-transfer; the pending result is discarded.
- op encoding:
  - 000 OR, 001 AND, 010 XOR, 011 NOR
  - 100 NAND, 101 XNOR, 110 pass A, 111 NOT A
- Operand B selection: effective B = accumulator if (ACC_EN && acc), else b.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, single-stage pipe).
  - Accept = in_valid && in_ready.
  - On accept: out <= result, out_valid <= 1. Latency is 1 cycle from accept to out_valid.
  - Result hold: if out_valid && !out_ready, then out, out_valid and the flags hold stable and in_ready=0.
  - Drain: if out_valid && out_ready && !in_valid, then out_valid <= 0 and out holds its last value.
  - Simultaneous drain and accept: new result loads and out_valid stays 1, giving full throughput of one per cycle.
- Accumulator (ACC_EN=1):
  - On accept with acc=1, accumulator <= result. A non-acc accept leaves the accumulator unchanged.
  - acc_clr=1 clears the accumulator at the clock edge regardless of handshake.
  - If acc_clr coincides with an acc accept, the operation uses 0 as effective B and the accumulator <= that result; the clear is applied first.
  - acc_clr does not affect out or out_valid.
- Flags (out_zero, out_ones, out_popcnt):
  - Registered together with out, so they are always consistent with out.
  - Valid whenever out_valid=1.
- Widths: no carries and no truncation. WIDTH=1 must work (out_popcnt is 1 bit).

Test Plan:
- Reset/basic OR: WIDTH=16, hold rst_n=0 for 2 clocks, then a=16'h00F0, b=16'h0F0F, op=000, in_valid=1, out_ready=1 → one cycle later out=16'h0FFF, out_valid=1, out_popcnt=12, out_zero=0.
- All ops: a=16'hA5A5, b=16'h0FF0, sweep op 000..111 back-to-back with out_ready=1 → out = 0xAFF5, 0x05A0, 0xAA55, 0x500A, 0xFA5F, 0x55AA, 0xA5A5, 0x5A5A on consecutive cycles with no bubbles.
- Backpressure: accept one op, hold out_ready=0 for 3 cycles while in_valid=1 with new data → in_ready=0 and out stable for 3 cycles. Release → the next result appears the following cycle and no data is lost or duplicated.
- Accumulate: acc_clr pulse, then acc=1, op=000 with a=0x0001, 0x0010, 0x0100 → out = 0x0001, 0x0011, 0x0111. Then acc=1, op=010, a=0x0111 → out=0x0000, out_zero=1.
- Clear/accumulate collision: accumulator=0x00FF, same cycle acc_clr=1 and an acc accept with op=000, a=0x1200 → out=0x1200 and accumulator=0x1200.
- Mid-operation reset: out_valid=1 with out_ready=0, assert rst_n=0 for 1 clock → out_valid=0, out=0, accumulator=0, in_ready=1 the next cycle. Also repeat the OR case at WIDTH=1: a=1, b=0 → out=1, out_ones=1.
